// File: rtl/redmule_tcdm_responder.sv
// TCDM slave model for RedMulE: byte-enabled word memory, Latency-stage read pipe, credit-limited response FIFO.
// Read data is valid Latency cycles after grant (FIFO falls through when empty); gnt is withheld while RspDepth reads are outstanding.
package redmule_pkg;
  parameter int unsigned DATA_W = 288;
endpackage

interface hci_core_intf #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned UW = 1,
  parameter int unsigned IW = 8
) ();
  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [DW-1:0] data;
  logic [DW/8-1:0] be;
  logic [IW-1:0] id;
  logic          r_ready;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [UW-1:0] r_user;
  logic [IW-1:0] r_id;
  logic          r_opc;

  modport master (
    output req, add, wen, data, be, id, r_ready,
    input  gnt, r_valid, r_data, r_user, r_id, r_opc
  );
  modport slave (
    input  req, add, wen, data, be, id, r_ready,
    output gnt, r_valid, r_data, r_user, r_id, r_opc
  );
endinterface

module redmule_tcdm_responder #(
  parameter int unsigned DW        = redmule_pkg::DATA_W,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned MemWords  = 4096,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 4,
  parameter int unsigned ID_WIDTH  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        stall_i,
  hci_core_intf.slave tcdm,
  output logic        busy_o,
  output logic        err_o
);
  localparam int unsigned BeW   = DW / 8;
  localparam int unsigned OffW  = $clog2(BeW);
  localparam int unsigned MemAw = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int unsigned PtrW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CrW   = $clog2(RspDepth + 1);

  logic [DW-1:0]       r_mem [MemWords];
  logic [AddrWidth-1:0] w_word_idx;
  logic [MemAw-1:0]    w_mem_idx;
  logic                w_oor;
  logic                w_gnt;
  logic                w_rd_gnt;
  logic                w_wr_gnt;

  logic [CrW-1:0]      r_credits;
  logic [CrW-1:0]      w_credits_nxt;
  logic                r_busy;
  logic                r_err;

  logic [Latency-1:0]  r_pipe_vld;
  logic [DW-1:0]       r_pipe_dat [Latency];
  logic [ID_WIDTH-1:0] r_pipe_id  [Latency];
  logic                w_last_vld;

  logic [DW-1:0]       r_fifo_dat [RspDepth];
  logic [ID_WIDTH-1:0] r_fifo_id  [RspDepth];
  logic [PtrW-1:0]     r_wptr;
  logic [PtrW-1:0]     r_rptr;
  logic [CrW-1:0]      r_fcnt;
  logic                w_fifo_empty;
  logic                w_fifo_push;
  logic                w_fifo_pop;
  logic                w_rvalid;
  logic                w_rsp_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_word_idx = tcdm.add >> OffW;
  assign w_mem_idx  = w_word_idx[MemAw-1:0];
  assign w_oor      = (w_word_idx >= AddrWidth'(MemWords));
  assign w_gnt      = tcdm.req & ~stall_i & ~clear_i & (r_credits < CrW'(RspDepth));
  assign w_rd_gnt   = w_gnt & tcdm.wen;
  assign w_wr_gnt   = w_gnt & ~tcdm.wen;

  always_ff @(posedge clk_i) begin
    if (w_wr_gnt && !w_oor) begin
      for (int b = 0; b < BeW; b++) begin
        if (tcdm.be[b]) r_mem[w_mem_idx][8*b +: 8] <= tcdm.data[8*b +: 8];
      end
    end
  end

  // Payload registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (w_rd_gnt) begin
      r_pipe_dat[0] <= w_oor ? '0 : r_mem[w_mem_idx];
      r_pipe_id[0]  <= tcdm.id;
    end
    for (int s = 1; s < Latency; s++) begin
      r_pipe_dat[s] <= r_pipe_dat[s-1];
      r_pipe_id[s]  <= r_pipe_id[s-1];
    end
    if (w_fifo_push) begin
      r_fifo_dat[r_wptr] <= r_pipe_dat[Latency-1];
      r_fifo_id[r_wptr]  <= r_pipe_id[Latency-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pipe_vld <= '0;
    end else if (clear_i) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_gnt;
      for (int s = 1; s < Latency; s++) r_pipe_vld[s] <= r_pipe_vld[s-1];
    end
  end

  assign w_last_vld   = r_pipe_vld[Latency-1];
  assign w_fifo_empty = (r_fcnt == '0);
  // The credit limit guarantees the FIFO has room whenever the pipe delivers.
  assign w_fifo_push  = w_last_vld & ~(w_fifo_empty & tcdm.r_ready);
  assign w_fifo_pop   = ~w_fifo_empty & tcdm.r_ready;
  assign w_rvalid     = ~w_fifo_empty | w_last_vld;
  assign w_rsp_pop    = w_rvalid & tcdm.r_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else if (clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_fifo_push) r_wptr <= ptr_inc(r_wptr);
      if (w_fifo_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_fifo_push && !w_fifo_pop)      r_fcnt <= r_fcnt + CrW'(1);
      else if (!w_fifo_push && w_fifo_pop) r_fcnt <= r_fcnt - CrW'(1);
    end
  end

  always_comb begin
    w_credits_nxt = r_credits;
    if (clear_i)                       w_credits_nxt = '0;
    else if (w_rd_gnt && !w_rsp_pop)   w_credits_nxt = r_credits + CrW'(1);
    else if (!w_rd_gnt && w_rsp_pop)   w_credits_nxt = r_credits - CrW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_credits <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_credits <= w_credits_nxt;
      r_busy    <= (w_credits_nxt != '0);
      r_err     <= r_err | (w_gnt & w_oor);
    end
  end

  assign tcdm.gnt     = w_gnt;
  assign tcdm.r_valid = w_rvalid;
  assign tcdm.r_data  = w_fifo_empty ? r_pipe_dat[Latency-1] : r_fifo_dat[r_rptr];
  assign tcdm.r_id    = w_fifo_empty ? r_pipe_id[Latency-1]  : r_fifo_id[r_rptr];
  assign tcdm.r_user  = '0;
  assign tcdm.r_opc   = 1'b0;
  assign busy_o       = r_busy;
  assign err_o        = r_err;

endmodule
